pipe_stage_reg: RTL

- Generic, parametrised pipeline stage register for the MIPS pipeline; replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle, with a valid/ready handshake, stall back-pressure and flush (bubble insertion).
- Optional two-entry skid mode gives a fully registered ready path with no throughput loss.
- Control fields are zeroed whenever the stage holds no valid beat, so downstream stages always see a NOP.

---
 rtl/pipe_stage_reg_pkg.sv | 20 ++
 rtl/pipe_stage_reg_if.sv | 42 ++++
 rtl/pipe_stage_reg_slot.sv | 54 +++++
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the generic pipeline stage register.
//                The state encoding equals the stage occupancy:
//                EMPTY = 0 beats, ONE = 1 beat, TWO = 2 beats.
//                Default bundle widths match the ID/EX stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 16;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : Handshake and bundle signals of one pipeline stage register.
//                slave  : the stage register itself.
//                master : the surrounding logic (upstream producer plus
//                         downstream consumer).
//  Signals     : i_valid/o_ready/i_data/i_ctrl/i_flush  upstream side
//                o_valid/i_ready/o_data/o_ctrl          downstream side
//                o_count                                occupancy 0..2
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
);

    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [CTRL_W-1:0] i_ctrl;
    logic              i_flush;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CTRL_W-1:0] o_ctrl;
    logic [1:0]        o_count;

    modport master (
        output i_valid, i_data, i_ctrl, i_flush, i_ready,
        input  o_ready, o_valid, o_data, o_ctrl, o_count
    );

    modport slave (
        input  i_valid, i_data, i_ctrl, i_flush, i_ready,
        output o_ready, o_valid, o_data, o_ctrl, o_count
    );

endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One register entry of a pipeline stage: valid bit, data
//                bundle and control bundle.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                i_load         capture i_data/i_ctrl and mark entry valid
//                i_clear        invalidate entry and zero its control bundle
//                               (data is kept); wins over i_load
//                i_data/i_ctrl  bundles to capture
//                o_valid/o_data/o_ctrl  entry contents
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_clear,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic [CTRL_W-1:0] i_ctrl,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic [CTRL_W-1:0]      o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            // Control is zeroed so an empty entry always reads as a NOP.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic MIPS pipeline stage register (IF/ID, ID/EX, EX/MEM,
//                MEM/WB) with valid/ready handshake, stall back-pressure and
//                flush. SKID=1 adds a skid entry so o_ready is a flop output
//                without losing throughput; SKID=0 is a single entry with
//                combinational o_ready.
//  Ports       : clk, rst   clock, synchronous active-high reset
//                bus        pipe_stage_reg_if.slave (handshake, bundles,
//                           flush, occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_stage_reg_if.slave   bus
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;

    logic              w_main_load;
    logic              w_main_clear;
    logic [DATA_W-1:0] w_main_din;
    logic [CTRL_W-1:0] w_main_cin;
    logic              w_main_valid;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;

    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    // A flushed input beat is dropped even when o_ready reads 1.
    assign w_in_xfer  = bus.i_valid & w_ready & ~bus.i_flush;
    assign w_out_xfer = w_main_valid & bus.i_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_in_xfer)                w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer)       w_state_nxt = ST_TWO;
                    else if (!w_in_xfer && w_out_xfer)  w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (w_out_xfer)               w_state_nxt = ST_ONE;
                default:                                w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main entry loads a fresh beat when it is free or being drained, and
    // takes the skid beat when draining from TWO.
    assign w_main_load  = ((r_state == ST_EMPTY) && w_in_xfer)
                        | ((r_state == ST_ONE)   && w_in_xfer && w_out_xfer)
                        | ((r_state == ST_TWO)   && w_out_xfer);
    assign w_main_clear = bus.i_flush
                        | ((r_state == ST_ONE) && w_out_xfer && !w_in_xfer);
    assign w_main_din   = (r_state == ST_TWO) ? w_skid_data : bus.i_data;
    assign w_main_cin   = (r_state == ST_TWO) ? w_skid_ctrl : bus.i_ctrl;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .i_ctrl  (w_main_cin),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_ready;
            logic w_skid_load;
            logic w_skid_clear;

            assign w_skid_load  = (r_state == ST_ONE) && w_in_xfer && !w_out_xfer;
            assign w_skid_clear = bus.i_flush | ((r_state == ST_TWO) && w_out_xfer);

            // Registered ready: drop it only once both entries will be full.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ready <= 1'b1;
                end else begin
                    r_ready <= (w_state_nxt != ST_TWO);
                end
            end

            assign w_ready = r_ready;

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  (bus.i_data),
                .i_ctrl  (bus.i_ctrl),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_data),
                .o_ctrl  (w_skid_ctrl)
            );
        end else begin : g_noskid
            // Single entry: accept whenever the held beat leaves this cycle.
            assign w_ready      = ~w_main_valid | bus.i_ready;
            assign w_skid_valid = 1'b0;
            assign w_skid_data  = '0;
            assign w_skid_ctrl  = '0;
        end
    endgenerate

    assign bus.o_ready = w_ready;
    assign bus.o_valid = w_main_valid;
    assign bus.o_data  = w_main_data;
    assign bus.o_ctrl  = w_main_ctrl;
    assign bus.o_count = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule : pipe_stage_reg
`default_nettype wire
